// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and helpers for the line buffer controller.
//   lbc_state_e : controller FSM state encoding (Idle=0, Cfg=1, Wait=2, Active=3)
//   cfg_valid() : true when a requested width/height can be served by delay_mem
package line_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCfg    = 2'd1,
    StWait   = 2'd2,
    StActive = 2'd3
  } lbc_state_e;

  // Wide enough for any settle time in 1..15.
  localparam int unsigned SettleCntW = 4;

  function automatic logic cfg_valid(input int unsigned width, input int unsigned height,
                                     input int unsigned max_width);
    return (width >= 2) && (width <= max_width) && (height >= 2);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_pos_counter.sv
// Column/row position tracker for the pixel stream.
//   clk_i, rst_ni     : clock, async active-low reset
//   clr_i             : synchronous clear of both counters (wins over en_i)
//   en_i              : advance by one pixel
//   width_i, height_i : current line length / rows per frame
//   sol_o/eol_o       : current pixel is first/last of its row
//   sof_o/eof_o       : current pixel is first/last of the frame
//   line_o            : current row is not the first (delayed line holds real data)
module line_buf_ctrl_pos_counter #(
  parameter int unsigned ColW = 8,
  parameter int unsigned RowW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [ColW-1:0] width_i,
  input  logic [RowW-1:0] height_i,
  output logic            sol_o,
  output logic            eol_o,
  output logic            sof_o,
  output logic            eof_o,
  output logic            line_o
);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            last_row;

  assign last_row = (row_q == height_i - RowW'(1));
  assign sol_o    = (col_q == '0);
  assign eol_o    = (col_q == width_i - ColW'(1));
  assign sof_o    = (row_q == '0) && sol_o;
  assign eof_o    = last_row && eol_o;
  assign line_o   = (row_q != '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (eol_o) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequences one delay_mem instance as a single-line buffer.
//   cfg_*      : host configuration (width/height latched on cfg_set_i)
//   cfg_err_o  : one-cycle pulse for a rejected configuration
//   busy_o     : controller is not idle
//   up_*       : pixel source handshake (beat = up_val_i & up_rdy_o)
//   mem_*      : drive delay_mem cfg_delay/cfg_set/up_data/up_val
//   tag_*      : position tags aligned with mem_val_o
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int unsigned ImgWidth  = 8,
  parameter int unsigned MemAwidth = 8,
  parameter int unsigned MemDepth  = 15,
  parameter int unsigned DimWidth  = 16,
  parameter int unsigned Settle    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MemAwidth-1:0] cfg_width_i,
  input  logic [DimWidth-1:0]  cfg_height_i,
  input  logic                 cfg_set_i,
  output logic                 cfg_err_o,
  output logic                 busy_o,
  input  logic [ImgWidth-1:0]  up_data_i,
  input  logic                 up_val_i,
  output logic                 up_rdy_o,
  output logic [MemAwidth-1:0] mem_delay_o,
  output logic                 mem_set_o,
  output logic [ImgWidth-1:0]  mem_data_o,
  output logic                 mem_val_o,
  output logic                 tag_line_o,
  output logic                 tag_sol_o,
  output logic                 tag_eol_o,
  output logic                 tag_sof_o,
  output logic                 tag_eof_o
);

  lbc_state_e state_q, state_d;

  logic [MemAwidth-1:0]  width_q, width_d, pend_w_q, pend_w_d;
  logic [DimWidth-1:0]   height_q, height_d, pend_h_q, pend_h_d;
  logic                  pend_q, pend_d;
  logic [SettleCntW-1:0] settle_q, settle_d;

  logic                  cfg_err_q, cfg_err_d;
  logic                  mem_set_q, mem_set_d;
  logic [MemAwidth-1:0]  mem_delay_q, mem_delay_d;
  logic [ImgWidth-1:0]   mem_data_q, mem_data_d;
  logic                  mem_val_q;
  logic [4:0]            tags_q, tags_d;

  logic cfg_ok, beat, enter_cfg;
  logic pos_sol, pos_eol, pos_sof, pos_eof, pos_line;

  assign cfg_ok   = cfg_valid(32'(cfg_width_i), 32'(cfg_height_i), MemDepth);
  assign up_rdy_o = (state_q == StActive);
  assign busy_o   = (state_q != StIdle);
  assign beat     = up_val_i && up_rdy_o;

  line_buf_ctrl_pos_counter #(
    .ColW(MemAwidth),
    .RowW(DimWidth)
  ) u_pos (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (state_q != StActive),
    .en_i    (beat),
    .width_i (width_q),
    .height_i(height_q),
    .sol_o   (pos_sol),
    .eol_o   (pos_eol),
    .sof_o   (pos_sof),
    .eof_o   (pos_eof),
    .line_o  (pos_line)
  );

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    pend_d    = pend_q;
    pend_w_d  = pend_w_q;
    pend_h_d  = pend_h_q;
    settle_d  = settle_q;
    cfg_err_d = 1'b0;
    enter_cfg = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_set_i) begin
          if (cfg_ok) begin
            width_d   = cfg_width_i;
            height_d  = cfg_height_i;
            enter_cfg = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StCfg: begin
        settle_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (settle_q == SettleCntW'(Settle - 1)) begin
          state_d = StActive;
        end else begin
          settle_d = settle_q + SettleCntW'(1);
        end
      end
      StActive: begin
        // A request landing on the eof beat itself becomes pending first, so it
        // is applied by the same frame-boundary logic below.
        if (cfg_set_i) begin
          if (cfg_ok) begin
            pend_d   = 1'b1;
            pend_w_d = cfg_width_i;
            pend_h_d = cfg_height_i;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (beat && pos_eof && pend_d) begin
          pend_d    = 1'b0;
          width_d   = pend_w_d;
          height_d  = pend_h_d;
          enter_cfg = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_cfg) begin
      state_d = StCfg;
    end
  end

  // Output registers: mem_delay only changes when a new config is issued.
  always_comb begin
    mem_set_d   = enter_cfg;
    mem_delay_d = enter_cfg ? width_d : mem_delay_q;
    mem_data_d  = beat ? up_data_i : mem_data_q;
    tags_d      = beat ? {pos_line, pos_sol, pos_eol, pos_sof, pos_eof} : 5'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      width_q     <= '0;
      height_q    <= '0;
      pend_q      <= 1'b0;
      pend_w_q    <= '0;
      pend_h_q    <= '0;
      settle_q    <= '0;
      cfg_err_q   <= 1'b0;
      mem_set_q   <= 1'b0;
      mem_delay_q <= '0;
      mem_data_q  <= '0;
      mem_val_q   <= 1'b0;
      tags_q      <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      pend_q      <= pend_d;
      pend_w_q    <= pend_w_d;
      pend_h_q    <= pend_h_d;
      settle_q    <= settle_d;
      cfg_err_q   <= cfg_err_d;
      mem_set_q   <= mem_set_d;
      mem_delay_q <= mem_delay_d;
      mem_data_q  <= mem_data_d;
      mem_val_q   <= beat;
      tags_q      <= tags_d;
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign mem_set_o   = mem_set_q;
  assign mem_delay_o = mem_delay_q;
  assign mem_data_o  = mem_data_q;
  assign mem_val_o   = mem_val_q;
  assign tag_line_o  = tags_q[4];
  assign tag_sol_o   = tags_q[3];
  assign tag_eol_o   = tags_q[2];
  assign tag_sof_o   = tags_q[1];
  assign tag_eof_o   = tags_q[0];

endmodule

// File: tb/tb_line_buf_ctrl.sv
module tb_line_buf_ctrl;

  localparam int unsigned Settle   = 2;
  localparam int unsigned MemDepth = 15;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  cfg_width_i = '0;
  logic [15:0] cfg_height_i = '0;
  logic        cfg_set_i = 1'b0;
  logic        cfg_err_o, busy_o, up_rdy_o, mem_set_o, mem_val_o;
  logic [7:0]  up_data_i = '0;
  logic        up_val_i = 1'b0;
  logic [7:0]  mem_delay_o, mem_data_o;
  logic        tag_line_o, tag_sol_o, tag_eol_o, tag_sof_o, tag_eof_o;

  line_buf_ctrl #(
    .ImgWidth (8),
    .MemAwidth(8),
    .MemDepth (MemDepth),
    .DimWidth (16),
    .Settle   (Settle)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_width_i (cfg_width_i),
    .cfg_height_i(cfg_height_i),
    .cfg_set_i   (cfg_set_i),
    .cfg_err_o   (cfg_err_o),
    .busy_o      (busy_o),
    .up_data_i   (up_data_i),
    .up_val_i    (up_val_i),
    .up_rdy_o    (up_rdy_o),
    .mem_delay_o (mem_delay_o),
    .mem_set_o   (mem_set_o),
    .mem_data_o  (mem_data_o),
    .mem_val_o   (mem_val_o),
    .tag_line_o  (tag_line_o),
    .tag_sol_o   (tag_sol_o),
    .tag_eol_o   (tag_eol_o),
    .tag_sof_o   (tag_sof_o),
    .tag_eof_o   (tag_eof_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position is a single beat index n, with
  // col = n % w and row = n / w; readiness is a cycle timestamp.
  bit          m_cfgd, m_rdy, m_pend;
  int unsigned m_w, m_h, m_pw, m_ph, m_n, m_cyc, m_ready_at;
  bit          e_err, e_set, e_val, e_line, e_sol, e_eol, e_sof, e_eof;
  int unsigned e_delay, e_data;

  function automatic bit ok_cfg(input int unsigned w, input int unsigned h);
    return w >= 2 && w <= MemDepth && h >= 2;
  endfunction

  task automatic model_reset();
    m_cfgd = 0; m_rdy = 0; m_pend = 0; m_n = 0; m_w = 0; m_h = 0;
    e_err = 0; e_set = 0; e_val = 0; e_delay = 0; e_data = 0;
    {e_line, e_sol, e_eol, e_sof, e_eof} = '0;
  endtask

  task automatic model_accept(input int unsigned w, input int unsigned h);
    m_cfgd = 1; m_w = w; m_h = h; m_n = 0;
    e_set = 1; e_delay = w;
    // One config cycle plus Settle wait cycles before pixels are taken.
    m_ready_at = m_cyc + 2 + Settle;
  endtask

  task automatic model_step(input bit cs, input int unsigned cw, input int unsigned ch,
                            input bit val, input int unsigned data);
    bit beat;
    int unsigned col, row;
    beat  = val && m_rdy;
    e_err = 0; e_set = 0; e_val = beat;
    {e_line, e_sol, e_eol, e_sof, e_eof} = '0;
    if (!m_cfgd) begin
      if (cs) begin
        if (ok_cfg(cw, ch)) model_accept(cw, ch);
        else e_err = 1;
      end
    end else if (m_rdy) begin
      if (cs) begin
        if (ok_cfg(cw, ch)) begin m_pend = 1; m_pw = cw; m_ph = ch; end
        else e_err = 1;
      end
      if (beat) begin
        col = m_n % m_w;
        row = m_n / m_w;
        e_data = data;
        e_line = row != 0;
        e_sol  = col == 0;
        e_eol  = col == m_w - 1;
        e_sof  = m_n == 0;
        e_eof  = m_n == m_w * m_h - 1;
        m_n++;
        if (m_n == m_w * m_h) begin
          m_n = 0;
          if (m_pend) begin m_pend = 0; model_accept(m_pw, m_ph); end
        end
      end
    end
    m_cyc++;
    m_rdy = m_cfgd && (m_cyc >= m_ready_at);
  endtask

  task automatic check_all();
    chk("cfg_err", cfg_err_o, e_err);
    chk("busy", busy_o, m_cfgd);
    chk("up_rdy", up_rdy_o, m_rdy);
    chk("mem_set", mem_set_o, e_set);
    chk("mem_delay", mem_delay_o, e_delay);
    chk("mem_val", mem_val_o, e_val);
    if (e_val) chk("mem_data", mem_data_o, e_data);
    chk("tag_line", tag_line_o, e_line);
    chk("tag_sol", tag_sol_o, e_sol);
    chk("tag_eol", tag_eol_o, e_eol);
    chk("tag_sof", tag_sof_o, e_sof);
    chk("tag_eof", tag_eof_o, e_eof);
  endtask

  task automatic cycle(input bit cs, input int unsigned cw, input int unsigned ch,
                       input bit val, input int unsigned data);
    cfg_set_i    = cs;
    cfg_width_i  = cw[7:0];
    cfg_height_i = ch[15:0];
    up_val_i     = val;
    up_data_i    = data[7:0];
    @(posedge clk_i);
    model_step(cs, cw, ch, val, data);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_up_rdy"}, up_rdy_o, 0);
    chk({tag, "_cfg_err"}, cfg_err_o, 0);
    chk({tag, "_mem_set"}, mem_set_o, 0);
    chk({tag, "_mem_delay"}, mem_delay_o, 0);
    chk({tag, "_mem_val"}, mem_val_o, 0);
    chk({tag, "_mem_data"}, mem_data_o, 0);
    chk({tag, "_tags"}, {tag_line_o, tag_sol_o, tag_eol_o, tag_sof_o, tag_eof_o}, 0);
  endtask

  task automatic do_reset();
    cfg_set_i = 0; up_val_i = 0;
    rst_ni = 0;
    #2;
    model_reset();
    check_zero("reset");
    @(negedge clk_i);
    rst_ni = 1;
    #1;
  endtask

  // Issue a config from idle and idle the stream until the model says ready.
  task automatic do_cfg(input int unsigned w, input int unsigned h);
    cycle(1, w, h, 0, 0);
    for (int i = 0; i < 20 && !m_rdy; i++) cycle(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int unsigned w;
    int unsigned h;
    bit          ok;
  } cfg_vec_t;

  cfg_vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sets, b;

    // Configuration validity table (each from a fresh reset).
    vecs[0] = '{w: 1,  h: 3,     ok: 0};
    vecs[1] = '{w: 16, h: 3,     ok: 0};
    vecs[2] = '{w: 4,  h: 1,     ok: 0};
    vecs[3] = '{w: 2,  h: 2,     ok: 1};
    vecs[4] = '{w: 15, h: 2,     ok: 1};
    vecs[5] = '{w: 0,  h: 5,     ok: 0};
    vecs[6] = '{w: 4,  h: 0,     ok: 0};
    vecs[7] = '{w: 15, h: 65535, ok: 1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cycle(1, vecs[i].w, vecs[i].h, 0, 0);
      chk("tbl_cfg_err", cfg_err_o, !vecs[i].ok);
      chk("tbl_mem_set", mem_set_o, vecs[i].ok);
      chk("tbl_busy", busy_o, vecs[i].ok);
      cycle(0, 0, 0, 0, 0);
      chk("tbl_err_pulse", cfg_err_o, 0);
      chk("tbl_set_pulse", mem_set_o, 0);
    end

    // Basic 4x3 frame, data 1..12.
    do_reset();
    cycle(1, 4, 3, 0, 0);
    chk("t1_mem_set", mem_set_o, 1);
    chk("t1_mem_delay", mem_delay_o, 4);
    for (int i = 0; i < Settle; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("t1_rdy_wait", up_rdy_o, 0);
    end
    cycle(0, 0, 0, 0, 0);
    chk("t1_rdy_up", up_rdy_o, 1);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0, 1, k);
      chk("t1_data", mem_data_o, k);
      chk("t1_line", tag_line_o, k >= 5);
      chk("t1_eol", tag_eol_o, k % 4 == 0);
      chk("t1_sof", tag_sof_o, k == 1);
      chk("t1_eof", tag_eof_o, k == 12);
    end

    // Invalid configs from idle.
    do_reset();
    cycle(1, 1, 3, 0, 0);  chk("t2_err_w1", cfg_err_o, 1);
    cycle(1, 16, 3, 0, 0); chk("t2_err_w16", cfg_err_o, 1);
    cycle(1, 4, 1, 0, 0);  chk("t2_err_h1", cfg_err_o, 1);
    cycle(0, 0, 0, 0, 0);  chk("t2_idle", busy_o, 0);

    // 4x2 with gaps every other cycle.
    do_reset();
    do_cfg(4, 2);
    b = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, i % 2 == 0, 100 + i);
      if (i % 2 == 0) begin
        b++;
        chk("t3_eof", tag_eof_o, b == 8);
      end else begin
        chk("t3_gap_val", mem_val_o, 0);
      end
    end

    // Mid-frame reconfig to 5x2 during a 4x2 frame.
    do_reset();
    do_cfg(4, 2);
    for (int k = 1; k <= 8; k++) begin
      cycle(k == 3, 5, 2, 1, k);
      chk("t4_old_eol", tag_eol_o, k % 4 == 0);
      chk("t4_no_early_set", mem_set_o, k == 8);
    end
    chk("t4_new_delay", mem_delay_o, 5);
    for (int i = 0; i < 20 && !m_rdy; i++) cycle(0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 0, 1, k);
      chk("t4_new_eol", tag_eol_o, k == 5 || k == 10);
    end

    // Async reset mid-row.
    do_reset();
    do_cfg(4, 3);
    for (int k = 1; k <= 6; k++) cycle(0, 0, 0, 1, k);
    up_val_i = 0;
    rst_ni = 0;
    #1;
    model_reset();
    check_zero("t5_async");
    @(negedge clk_i);
    rst_ni = 1;
    #1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i);
    chk("t5_stays_idle", busy_o, 0);

    // Three continuous 4x3 frames.
    do_reset();
    do_cfg(4, 3);
    sets = 0;
    for (int k = 1; k <= 36; k++) begin
      cycle(0, 0, 0, 1, k);
      chk("t6_sof", tag_sof_o, k == 1 || k == 13 || k == 25);
      sets += mem_set_o;
    end
    chk("t6_no_mem_set", sets, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit cs;
      cs = m_cfgd ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 3) == 0);
      cycle(cs, $urandom_range(0, 17), $urandom_range(0, 4),
            $urandom_range(0, 3) != 0, $urandom_range(0, 255));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
